// File: rtl/priority_code_fifo_if.sv
// Handshake/status bundle between the priority-code FIFO and its consumer.
// Combinational wiring only, no latency.
// The consumer throttles the FIFO through rd; producer events are never stalled.
interface priority_code_fifo_if #(
  parameter int AW = 2
);
  logic [2:0]  y;
  logic        done;
  logic        rd;
  logic        clr;
  logic [2:0]  dout;
  logic        valid;
  logic        full;
  logic [AW:0] count;
  logic        ovf;

  // Driver side: encoder outputs, pop strobe and clear.
  modport master (output y, done, rd, clr, input dout, valid, full, count, ovf);
  // FIFO side.
  modport slave  (input y, done, rd, clr, output dout, valid, full, count, ovf);
endinterface

// File: rtl/priority_code_fifo.sv
// Queues each new 8-to-3 priority-encoder code in a show-ahead FIFO for a slower reader.
// Latency: encoder change at edge N is sampled at N+1 and written at N+2; dout is show-ahead.
// Backpressure: none upstream; events arriving while full (without a pop) are dropped and ovf sticks.
module priority_code_fifo #(
  parameter int DEPTH = 4,  // power of two, 2..16
  parameter int AW    = 2   // log2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  priority_code_fifo_if.slave pcf
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [2:0]    y_q;
  logic [2:0]    last_y_q;
  logic          done_q;
  logic          done_qq;
  logic          primed_q;  // set after the first real sample following reset
  logic          armed_q;   // set once a genuine Done=0 sample has been seen
  logic [2:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          evt, full, empty, push, pop;

  // Sample the encoder and track the edge/code-change history used by event detection.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      y_q      <= '0;
      done_q   <= 1'b0;
      done_qq  <= 1'b0;
      primed_q <= 1'b0;
      armed_q  <= 1'b0;
      last_y_q <= '0;
    end else begin
      y_q      <= pcf.y;
      done_q   <= pcf.done;
      done_qq  <= done_q;
      primed_q <= 1'b1;
      // A Done held high across reset must not count as a rising edge, so events
      // stay blocked until a real low sample has been observed.
      armed_q  <= armed_q | (primed_q & ~done_q);
      if (evt) begin
        last_y_q <= y_q;
      end
    end
  end

  // Event detect, push/pop qualification and next-state of pointers, count and overflow.
  always_comb begin
    full     = (count_q == FULL_CNT);
    empty    = (count_q == '0);
    evt      = armed_q && done_q && (!done_qq || (y_q != last_y_q));
    pop      = pcf.rd && !empty;
    push     = evt && (!full || pop) && !pcf.clr;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (pcf.clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
      // A pop in the same cycle frees the slot, so only an unserved full FIFO drops.
      if (evt && full && !pcf.rd) begin
        ovf_d = 1'b1;
      end
    end
  end

  // Pointer, occupancy and sticky overflow registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array; contents are only observable through dout while valid, so no reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= y_q;
    end
  end

  assign pcf.valid = !empty;
  assign pcf.full  = full;
  assign pcf.count = count_q;
  assign pcf.ovf   = ovf_q;
  assign pcf.dout  = empty ? 3'b000 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_priority_code_fifo.sv
// Self-checking bench for priority_code_fifo: directed scenarios plus random traffic,
// all compared every cycle against a queue-based event model, with literal spot checks.
`timescale 1ns/1ps
module tb_priority_code_fifo;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  priority_code_fifo_if #(.AW(AW)) bus ();

  priority_code_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .pcf     (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The FIFO is a queue of codes. An encoder sample produces an event when Done is
  // high and either the previous sample had Done low or the code differs from the
  // last accepted event code, and only if some earlier sample since reset had Done low.
  logic [2:0] mq[$];
  bit         m_ovf;
  bit         s_vld;
  bit         s_done;
  logic [2:0] s_y;
  bit         prev_done;
  bit         seen_low;
  logic [2:0] last_y;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_ovf     = 1'b0;
        s_vld     = 1'b0;
        s_done    = 1'b0;
        s_y       = 3'd0;
        prev_done = 1'b0;
        seen_low  = 1'b0;
        last_y    = 3'd0;
      end else begin
        bit evt;
        evt = s_vld && s_done && seen_low && (!prev_done || (s_y != last_y));
        if (evt) last_y = s_y;
        if (bus.clr) begin
          mq.delete();
          m_ovf = 1'b0;
        end else begin
          if (bus.rd && mq.size() > 0) void'(mq.pop_front());
          if (evt) begin
            if (mq.size() < DEPTH) mq.push_back(s_y);
            else m_ovf = 1'b1;
          end
        end
        if (s_vld) begin
          seen_low  = seen_low | !s_done;
          prev_done = s_done;
        end
        s_vld  = 1'b1;
        s_done = bus.done;
        s_y    = bus.y;
      end
    end
  end

  // Per-cycle comparison of every output against the model, away from the clock edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("m_count", 32'(bus.count), 32'(mq.size()));
        check("m_valid", 32'(bus.valid), 32'(mq.size() != 0));
        check("m_full",  32'(bus.full),  32'(mq.size() == DEPTH));
        check("m_ovf",   32'(bus.ovf),   32'(m_ovf));
        check("m_dout",  32'(bus.dout),  (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pop_expect(input logic [2:0] exp, input string name);
    @(negedge clk);
    check(name, 32'(bus.dout), 32'(exp));
    check({name, "_valid"}, 32'(bus.valid), 32'd1);
    bus.rd = 1'b1;
    tick();
    bus.rd = 1'b0;
  endtask

  task automatic check_idle(input string name);
    check({name, "_count"}, 32'(bus.count), 32'd0);
    check({name, "_valid"}, 32'(bus.valid), 32'd0);
    check({name, "_full"},  32'(bus.full),  32'd0);
    check({name, "_ovf"},   32'(bus.ovf),   32'd0);
    check({name, "_dout"},  32'(bus.dout),  32'd0);
  endtask

  initial begin
    bus.y    = 3'd0;
    bus.done = 1'b0;
    bus.rd   = 1'b0;
    bus.clr  = 1'b0;
    rst_n    = 1'b0;

    // Reset state
    #12;
    check_idle("reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // 1: Done low, codes toggling -> nothing queued
    for (int i = 0; i < 8; i++) begin
      bus.y = 3'(i);
      tick();
    end
    @(negedge clk);
    check("t1_valid", 32'(bus.valid), 32'd0);
    check("t1_count", 32'(bus.count), 32'd0);
    check("t1_ovf",   32'(bus.ovf),   32'd0);

    // 2: rising Done with code 5, two-edge latency, then one pop
    bus.y    = 3'd5;
    bus.done = 1'b1;
    tick();
    @(negedge clk);
    check("t2_lat_valid", 32'(bus.valid), 32'd0);
    tick();
    @(negedge clk);
    check("t2_valid", 32'(bus.valid), 32'd1);
    check("t2_dout",  32'(bus.dout),  32'd5);
    bus.rd = 1'b1;
    tick();
    bus.rd = 1'b0;
    @(negedge clk);
    check("t2_pop_valid", 32'(bus.valid), 32'd0);
    check("t2_pop_count", 32'(bus.count), 32'd0);

    // 3: Done held, codes 2,6,6,7 -> three entries
    bus.y = 3'd2; tick();
    bus.y = 3'd6; tick();
    tick();
    bus.y = 3'd7; tick();
    tick(); tick();
    @(negedge clk);
    check("t3_count", 32'(bus.count), 32'd3);
    pop_expect(3'd2, "t3_pop0");
    pop_expect(3'd6, "t3_pop1");
    pop_expect(3'd7, "t3_pop2");
    @(negedge clk);
    check("t3_empty", 32'(bus.valid), 32'd0);

    // 4: six distinct events into a 4-deep FIFO
    bus.done = 1'b0;
    tick(); tick();
    bus.done = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      bus.y = 3'(i);
      tick();
      if (i == 4) begin
        tick();
        @(negedge clk);
        check("t4_full_at4", 32'(bus.full), 32'd1);
        check("t4_ovf_at4",  32'(bus.ovf),  32'd0);
      end
    end
    tick(); tick();
    @(negedge clk);
    check("t4_full",  32'(bus.full),  32'd1);
    check("t4_ovf",   32'(bus.ovf),   32'd1);
    check("t4_count", 32'(bus.count), 32'd4);
    pop_expect(3'd1, "t4_pop0");
    pop_expect(3'd2, "t4_pop1");
    pop_expect(3'd3, "t4_pop2");
    pop_expect(3'd4, "t4_pop3");
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    @(negedge clk);
    check("t4_clr_ovf",   32'(bus.ovf),   32'd0);
    check("t4_clr_count", 32'(bus.count), 32'd0);

    // 5: full FIFO with simultaneous event and pop
    for (int i = 1; i <= 4; i++) begin
      bus.y = 3'(i);
      tick();
    end
    tick(); tick();
    @(negedge clk);
    check("t5_fill", 32'(bus.count), 32'd4);
    bus.y = 3'd5;
    tick();
    bus.rd = 1'b1;
    tick();
    bus.rd = 1'b0;
    @(negedge clk);
    check("t5_same_count", 32'(bus.count), 32'd4);
    check("t5_same_ovf",   32'(bus.ovf),   32'd0);
    pop_expect(3'd2, "t5_pop0");
    pop_expect(3'd3, "t5_pop1");
    pop_expect(3'd4, "t5_pop2");
    pop_expect(3'd5, "t5_pop3");
    // refill, then ten cycles of aligned push+pop to walk the pointers around
    for (int i = 1; i <= 4; i++) begin
      bus.y = 3'(i);
      tick();
    end
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      bus.y  = 3'(i % 8);
      bus.rd = (i > 0);
      tick();
    end
    bus.rd = 1'b1;
    tick();
    bus.rd = 1'b0;
    @(negedge clk);
    check("t5_wrap_count", 32'(bus.count), 32'd4);
    check("t5_wrap_ovf",   32'(bus.ovf),   32'd0);
    pop_expect(3'd6, "t5_wpop0");
    pop_expect(3'd7, "t5_wpop1");
    pop_expect(3'd0, "t5_wpop2");
    pop_expect(3'd1, "t5_wpop3");

    // 6: asynchronous reset with three entries queued
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      bus.y = 3'(i);
      tick();
    end
    tick(); tick();
    @(negedge clk);
    check("t6_pre_count", 32'(bus.count), 32'd3);
    #1;
    rst_n = 1'b0;
    #1;
    check_idle("t6_async");
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    @(negedge clk);
    check("t6_held_count", 32'(bus.count), 32'd0);
    bus.done = 1'b0;
    tick(); tick();
    bus.done = 1'b1;
    tick(); tick(); tick();
    @(negedge clk);
    check("t6_fresh_count", 32'(bus.count), 32'd1);
    check("t6_fresh_dout",  32'(bus.dout),  32'd4);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) bus.done = ~bus.done;
      if ($urandom_range(0, 2) == 0) bus.y = 3'($urandom_range(0, 7));
      bus.rd  = ($urandom_range(0, 2) == 0);
      bus.clr = ($urandom_range(0, 99) == 0);
      if (i == 1500) begin
        #1;
        rst_n = 1'b0;
        #1;
        check_idle("rnd_async");
        tick();
        rst_n = 1'b1;
      end
      tick();
    end
    bus.rd  = 1'b0;
    bus.clr = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
